// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I datapath. It holds the IR and sequences the
// fetch/decode/execute/memory/writeback steps. Define MULTICYCLE_CTRL_ITYPE_EN to add OP-IMM (EXEC_I).
module multicycle_control #(
    parameter int RESET_STATE_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     iord,
    output logic                     ir_write,
    output logic [31:0]              ir_o,
    output logic                     pc_write,
    output logic                     pc_write_cond,
    output logic [1:0]               pc_src,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               ALUOp,
    output logic [2:0]               alu_funct3,
    output logic                     alu_funct7,
    output logic                     reg_write,
    output logic                     mem_to_reg,
    output logic                     illegal,
    output logic [RESET_STATE_W-1:0] state_o
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

    typedef enum logic [RESET_STATE_W-1:0] {
        S_IDLE     = RESET_STATE_W'(0),
        S_FETCH    = RESET_STATE_W'(1),
        S_DECODE   = RESET_STATE_W'(2),
        S_MEM_ADDR = RESET_STATE_W'(3),
        S_MEM_RD   = RESET_STATE_W'(4),
        S_MEM_WB   = RESET_STATE_W'(5),
        S_MEM_WR   = RESET_STATE_W'(6),
        S_EXEC_R   = RESET_STATE_W'(7),
        S_ALU_WB   = RESET_STATE_W'(8),
        S_BRANCH   = RESET_STATE_W'(9),
        S_ILLEGAL  = RESET_STATE_W'(10),
        S_EXEC_I   = RESET_STATE_W'(11)
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        ALUOp         = 2'b00;
        alu_funct7    = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    ir_d     = mem_rdata;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut while dispatching.
                alu_src_b = 2'b11;
                case (ir_q[6:0])
                    OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
                    OPC_RTYPE:           state_d = S_EXEC_R;
                    OPC_BRANCH:          state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_ITYPE_EN
                    OPC_ITYPE:           state_d = S_EXEC_I;
`endif
                    default:             state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (ir_q[6:0] == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a  = 2'b01;
                ALUOp      = 2'b10;
                alu_funct7 = ir_q[30];
                state_d    = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b01;
                ALUOp         = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                state_d       = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_ITYPE_EN
            S_EXEC_I: begin
                // funct7 stays 0 so addi with imm[10]=1 is never decoded as sub.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                ALUOp     = 2'b10;
                state_d   = S_ALU_WB;
            end
`endif
            default: state_d = S_ILLEGAL;
        endcase

        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    assign ir_o       = ir_q;
    assign alu_funct3 = ir_q[14:12];
    assign illegal    = illegal_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table-driven instruction vectors, reset corner
// sequences, and randomized instructions/wait states against a per-instruction state-sequence model.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, ALUOp;
    logic [2:0]  alu_funct3;
    logic        alu_funct7, reg_write, mem_to_reg, illegal;
    logic [31:0] ir_o;
    logic [3:0]  state_o;

    multicycle_control #(.RESET_STATE_W(4)) dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .ir_o(ir_o),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  st;
        bit  rdy;
    } cyc_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          fetch_wait;
        int          mem_wait;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_ir  = '0;
    cyc_t        exp_q[$];

`ifdef MULTICYCLE_CTRL_ITYPE_EN
    localparam bit ITYPE_ON = 1'b1;
`else
    localparam bit ITYPE_ON = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic logic [17:0] got_outs();
        return {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                alu_src_a, alu_src_b, ALUOp, alu_funct7, reg_write, mem_to_reg, illegal};
    endfunction

    // Expected control word for one state, straight from the state/output table.
    function automatic logic [17:0] exp_outs(input int st, input bit rdy, input logic [31:0] ir);
        logic       rq = 0, we = 0, ad = 0, irw = 0, pcw = 0, pcc = 0, f7 = 0, rw = 0, m2r = 0, il = 0;
        logic [1:0] ps = 0, sa = 0, sb = 0, op = 0;
        case (st)
            1:  begin rq = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            2:  sb = 2'b11;
            3:  begin sa = 2'b01; sb = 2'b10; end
            4:  begin rq = 1; ad = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin rq = 1; we = 1; ad = 1; end
            7:  begin sa = 2'b01; op = 2'b10; f7 = ir[30]; end
            8:  rw = 1;
            9:  begin sa = 2'b01; op = 2'b01; pcc = 1; ps = 2'b01; end
            10: il = 1;
            11: begin sa = 2'b01; sb = 2'b10; op = 2'b10; end
            default: ;
        endcase
        return {rq, we, ad, irw, pcw, pcc, ps, sa, sb, op, f7, rw, m2r, il};
    endfunction

    // Expected state trace for one instruction, FETCH through the last state before the next FETCH.
    task automatic build_trace(input logic [31:0] instr, input int fw, input int mw, output bit is_ill);
        logic [6:0] opc;
        opc = instr[6:0];
        exp_q.delete();
        is_ill = 0;
        for (int i = 0; i < fw; i++) exp_q.push_back('{1, 1'b0});
        exp_q.push_back('{1, 1'b1});
        exp_q.push_back('{2, 1'b0});
        if (opc == 7'b0000011) begin
            exp_q.push_back('{3, 1'b0});
            for (int i = 0; i < mw; i++) exp_q.push_back('{4, 1'b0});
            exp_q.push_back('{4, 1'b1});
            exp_q.push_back('{5, 1'b0});
        end else if (opc == 7'b0100011) begin
            exp_q.push_back('{3, 1'b0});
            for (int i = 0; i < mw; i++) exp_q.push_back('{6, 1'b0});
            exp_q.push_back('{6, 1'b1});
        end else if (opc == 7'b0110011) begin
            exp_q.push_back('{7, 1'b0});
            exp_q.push_back('{8, 1'b0});
        end else if (opc == 7'b1100011) begin
            exp_q.push_back('{9, 1'b0});
        end else if (opc == 7'b0010011 && ITYPE_ON) begin
            exp_q.push_back('{11, 1'b0});
            exp_q.push_back('{8, 1'b0});
        end else begin
            is_ill = 1;
            for (int i = 0; i < 20; i++) exp_q.push_back('{10, 1'b0});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_outs", 32'(got_outs()), 32'd0);
        chk("rst_ir", ir_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_state", 32'(state_o), 32'd0);
        chk("idle_outs", 32'(got_outs()), 32'd0);
        prev_ir = '0;
    endtask

    // Drives one instruction from FETCH; expects the DUT to be in (or about to enter) FETCH.
    task automatic run_instr(input string nm, input logic [31:0] instr, input int fw, input int mw);
        bit          is_ill;
        logic [31:0] eir;
        build_trace(instr, fw, mw, is_ill);
        foreach (exp_q[k]) begin
            @(negedge clk);
            if (exp_q[k].st == 1 || exp_q[k].st == 4 || exp_q[k].st == 6)
                mem_ready = exp_q[k].rdy;
            else
                mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = (exp_q[k].st == 1) ? instr : $urandom();
            #1;
            eir = (exp_q[k].st == 1) ? prev_ir : instr;
            chk({nm, "_state"}, 32'(state_o), 32'(exp_q[k].st));
            chk({nm, "_outs"}, 32'(got_outs()), 32'(exp_outs(exp_q[k].st, mem_ready, eir)));
            chk({nm, "_ir"}, ir_o, eir);
            chk({nm, "_f3"}, 32'(alu_funct3), 32'(eir[14:12]));
        end
        prev_ir = instr;
        if (is_ill) do_reset();
    endtask

    vec_t vecs[$];

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;

        vecs.push_back('{"add",    32'h002081B3, 0, 0});
        vecs.push_back('{"sub",    32'h402081B3, 1, 0});
        vecs.push_back('{"lw",     32'h00802283, 0, 2});
        vecs.push_back('{"sw",     32'h00502423, 0, 0});
        vecs.push_back('{"beq",    32'h00000463, 0, 0});
        vecs.push_back('{"sw_w",   32'h00502423, 2, 3});
        vecs.push_back('{"addi",   32'h00500093, 0, 0});
        vecs.push_back('{"lw0",    32'h00802283, 0, 0});
        vecs.push_back('{"ill7f",  32'h0000007F, 0, 0});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Let it reach FETCH and stall there, then reset mid-FETCH.
        repeat (3) @(negedge clk);
        #1;
        chk("stall_fetch", 32'(state_o), 32'd1);
        do_reset();

        foreach (vecs[i]) run_instr(vecs[i].name, vecs[i].instr, vecs[i].fetch_wait, vecs[i].mem_wait);

        // Reset while in EXEC_R: nothing from the aborted add may leak out afterwards.
        @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h002081B3;
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("abort_decode", 32'(state_o), 32'd2);
        @(negedge clk); #1;
        chk("abort_exec", 32'(state_o), 32'd7);
        do_reset();
        run_instr("after_abort", 32'h402081B3, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [6:0]  opc;
            logic [31:0] ins;
            case ($urandom_range(0, 9))
                0, 1: opc = 7'b0000011;
                2, 3: opc = 7'b0100011;
                4, 5: opc = 7'b0110011;
                6, 7: opc = 7'b1100011;
                8:    opc = 7'b0010011;
                default: opc = 7'($urandom());
            endcase
            ins = ($urandom() & 32'hFFFF_FF80) | {25'd0, opc};
            run_instr("rand", ins, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
